// File: rtl/latch_q_monitor.sv
// latch_q_monitor: synchronise, glitch-filter and edge-detect a latch output; count transitions and queue timestamped edge events.
// Ports:
//   clk, rstn            clock and asynchronous active-low reset
//   q_in                 latch q, asynchronous to clk
//   clr_cnt              synchronous clear of trans_cnt and overflow
//   q_filt, rise, fall   filtered level and one-cycle edge pulses
//   trans_cnt            saturating count of filtered transitions
//   evt_valid/evt_ready  2-entry event FIFO handshake; head is {evt_rise, evt_ts}
//   overflow             sticky flag, set when an event is dropped on a full FIFO
module latch_q_monitor #(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_CYCLES = 4,
  parameter int CNT_W = 8,
  parameter int TS_W = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             q_in,
  input  logic             clr_cnt,
  output logic             q_filt,
  output logic             rise,
  output logic             fall,
  output logic [CNT_W-1:0] trans_cnt,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic             evt_rise,
  output logic [TS_W-1:0]  evt_ts,
  output logic             overflow
);
  localparam int FW = $clog2(FILT_CYCLES + 1);
  logic [SYNC_STAGES-1:0] sync;
  logic [FW-1:0] fcnt;
  logic [TS_W-1:0] ts;
  logic [TS_W:0] e0, e1;
  logic [1:0] occ, wr_idx;
  logic s, upd, pop, drop;
  assign s = sync[SYNC_STAGES-1];
  assign upd = (s != q_filt) && (fcnt == FW'(FILT_CYCLES - 1));
  assign evt_valid = occ != 2'd0;
  assign pop = evt_valid && evt_ready;
  // slot the incoming event lands in once this cycle's pop has shifted the FIFO
  assign wr_idx = occ - {1'b0, pop};
  assign drop = upd && (wr_idx == 2'd2);
  assign {evt_rise, evt_ts} = e0;
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync <= '0;
      fcnt <= '0;
      q_filt <= 1'b0;
      rise <= 1'b0;
      fall <= 1'b0;
      ts <= '0;
      trans_cnt <= '0;
      overflow <= 1'b0;
      occ <= 2'd0;
      e0 <= '0;
      e1 <= '0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], q_in};
      fcnt <= (s == q_filt || upd) ? '0 : fcnt + 1'b1;
      if (upd) q_filt <= s;
      rise <= upd & s;
      fall <= upd & ~s;
      ts <= ts + 1'b1;
      trans_cnt <= clr_cnt ? '0 : (upd && trans_cnt != '1) ? trans_cnt + 1'b1 : trans_cnt;
      // a drop in the same cycle as a clear leaves the flag set
      overflow <= drop | (overflow & ~clr_cnt);
      occ <= occ + {1'b0, upd & ~drop} - {1'b0, pop};
      if (pop) e0 <= e1;
      if (upd && wr_idx == 2'd0) e0 <= {s, ts};
      if (upd && wr_idx == 2'd1) e1 <= {s, ts};
    end
  end
endmodule

// File: tb/tb_latch_q_monitor.sv
// tb_latch_q_monitor: randomized and directed bench for latch_q_monitor against a queue-based reference model.
module tb_latch_q_monitor;
  localparam int SS = 2;
  localparam int FC = 4;
  localparam int CW = 2;
  localparam int TW = 4;
  logic clk = 1'b0, rstn = 1'b1, q_in = 1'b0, clr_cnt = 1'b0, evt_ready = 1'b1;
  logic q_filt, rise, fall, evt_valid, evt_rise, overflow;
  logic [CW-1:0] trans_cnt;
  logic [TW-1:0] evt_ts;
  latch_q_monitor #(.SYNC_STAGES(SS), .FILT_CYCLES(FC), .CNT_W(CW), .TS_W(TW)) dut (
    .clk(clk), .rstn(rstn), .q_in(q_in), .clr_cnt(clr_cnt), .q_filt(q_filt), .rise(rise),
    .fall(fall), .trans_cnt(trans_cnt), .evt_valid(evt_valid), .evt_ready(evt_ready),
    .evt_rise(evt_rise), .evt_ts(evt_ts), .overflow(overflow)
  );
  always #5 clk = ~clk;
  typedef struct {bit r; int ts;} ev_t;
  ev_t fq[$];
  bit sh[$];
  bit m_filt, m_rise, m_fall, m_ovf;
  int m_run, m_ts, m_cnt;
  int n_chk = 0, n_pass = 0;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
  endtask
  function automatic void model_reset();
    m_filt = 0; m_rise = 0; m_fall = 0; m_ovf = 0;
    m_run = 0; m_ts = 0; m_cnt = 0;
    fq.delete();
    sh.delete();
    for (int i = 0; i < SS; i++) sh.push_back(1'b0);
  endfunction
  function automatic void model_edge();
    bit s, upd;
    ev_t e;
    s = sh[0];
    upd = 0;
    if (s != m_filt) begin
      m_run++;
      if (m_run == FC) begin upd = 1; m_run = 0; end
    end else m_run = 0;
    if (fq.size() != 0 && evt_ready) void'(fq.pop_front());
    m_ovf = m_ovf && !clr_cnt;
    if (upd) begin
      e.r = s;
      e.ts = m_ts;
      if (fq.size() < 2) fq.push_back(e);
      else m_ovf = 1;
    end
    m_cnt = clr_cnt ? 0 : (upd && m_cnt < (1 << CW) - 1) ? m_cnt + 1 : m_cnt;
    m_rise = upd && s;
    m_fall = upd && !s;
    if (upd) m_filt = s;
    m_ts = (m_ts + 1) % (1 << TW);
    void'(sh.pop_front());
    sh.push_back(q_in);
  endfunction
  task automatic compare_all();
    check("q_filt", q_filt, m_filt);
    check("rise", rise, m_rise);
    check("fall", fall, m_fall);
    check("trans_cnt", trans_cnt, m_cnt);
    check("evt_valid", evt_valid, fq.size() != 0);
    check("overflow", overflow, m_ovf);
    if (fq.size() != 0) begin
      check("evt_rise", evt_rise, fq[0].r);
      check("evt_ts", evt_ts, fq[0].ts);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    if (rstn) model_edge();
    else model_reset();
    #1 compare_all();
  endtask
  task automatic hold(input int n);
    repeat (n) tick();
  endtask
  task automatic async_reset(input int n);
    #2 rstn = 1'b0;
    model_reset();
    #1 compare_all();
    hold(n);
    rstn = 1'b1;
  endtask
  initial begin
    int lat, nr, sat_exp[5];
    logic [TW-1:0] t_at, t1, t2;
    sat_exp = '{1, 2, 3, 3, 3};
    model_reset();
    q_in = 1'b1;
    #1 rstn = 1'b0;
    hold(3);
    rstn = 1'b1;
    lat = 0;
    t_at = '0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (rise && lat == 0) begin lat = i; t_at = evt_ts; end
    end
    check("rst_rise_lat", lat, 6);
    check("rst_rise_ts", t_at, 5);
    q_in = 1'b0;
    hold(12);
    nr = 0;
    q_in = 1'b1;
    for (int i = 0; i < 15; i++) begin
      if (i == 3) q_in = 1'b0;
      tick();
      if (rise || fall) nr++;
    end
    check("glitch_edges", nr, 0);
    check("glitch_cnt", trans_cnt, 2);
    t1 = '0;
    t2 = '0;
    q_in = 1'b1;
    for (int i = 0; i < 18; i++) begin
      if (i == 6) q_in = 1'b0;
      tick();
      if (rise) t1 = evt_ts;
      if (fall) t2 = evt_ts;
    end
    check("pulse_ts_diff", TW'(t2 - t1), 6);
    check("pulse_cnt", trans_cnt, 3);
    clr_cnt = 1'b1;
    tick();
    clr_cnt = 1'b0;
    for (int k = 0; k < 5; k++) begin
      q_in = ~q_in;
      hold(8);
      check("sat_cnt", trans_cnt, sat_exp[k]);
    end
    q_in = ~q_in;
    hold(5);
    clr_cnt = 1'b1;
    tick();
    clr_cnt = 1'b0;
    check("clr_edge", rise | fall, 1);
    check("clr_wins", trans_cnt, 0);
    hold(4);
    evt_ready = 1'b0;
    clr_cnt = 1'b1;
    tick();
    clr_cnt = 1'b0;
    for (int k = 0; k < 3; k++) begin
      q_in = ~q_in;
      hold(8);
    end
    check("ovf_set", overflow, 1);
    check("ovf_valid", evt_valid, 1);
    evt_ready = 1'b1;
    hold(2);
    check("ovf_drain", evt_valid, 0);
    check("ovf_sticky", overflow, 1);
    clr_cnt = 1'b1;
    tick();
    clr_cnt = 1'b0;
    evt_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      q_in = ~q_in;
      hold(8);
    end
    q_in = ~q_in;
    hold(5);
    evt_ready = 1'b1;
    tick();
    check("fpp_edge", rise | fall, 1);
    check("fpp_ovf", overflow, 0);
    hold(4);
    check("fpp_drain", evt_valid, 0);
    q_in = ~q_in;
    hold(4);
    async_reset(2);
    hold(12);
    for (int it = 0; it < 800; it++) begin
      int len;
      q_in = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 9);
      for (int j = 0; j < len; j++) begin
        evt_ready = $urandom_range(0, 3) != 0;
        clr_cnt = $urandom_range(0, 40) == 0;
        tick();
      end
      clr_cnt = 1'b0;
      if ($urandom_range(0, 300) == 0) async_reset(1);
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/latch_q_monitor.md
# latch_q_monitor

Synchronous observer placed directly downstream of the `d_latch` stage; consumes the latch output `q` as an asynchronous input. Synchronises and glitch-filters it, flags rising and falling edges, and keeps a saturating transition count. Queues timestamped edge events on a valid/ready interface for a logger or bus bridge.

## Interface
- `SYNC_STAGES`, 2: synchroniser depth; legal range is 2 or more.
- `FILT_CYCLES`, 4: number of consecutive cycles the synced value must differ before it is accepted; legal range is 1 or more.
- `CNT_W`, 8: width of the transition counter.
- `TS_W`, 16: width of the timestamp.
- `clk`  in  1  single clock; all state is on the rising edge.
- `rstn`  in  1  asynchronous, active-low reset.
- `q_in`  in  1  latch `q`; asynchronous to `clk`.
- `clr_cnt`  in  1  synchronous clear of `trans_cnt` and `overflow`.
- `q_filt`  out  1  filtered level.
- `rise`  out  1  one-cycle pulse on a 0→1 change of `q_filt`.
- `fall`  out  1  one-cycle pulse on a 1→0 change of `q_filt`.
- `trans_cnt`  out  CNT_W  number of filtered transitions; saturates.
- `evt_valid`  out  1  FIFO head is valid.
- `evt_ready`  in  1  consumer accepts the head.
- `evt_rise`  out  1  head edge type: 1 = rise, 0 = fall.
- `evt_ts`  out  TS_W  head timestamp.
- `overflow`  out  1  sticky flag: an event was dropped.

## Operation
- **Reset:** asserting `rstn` low clears everything, asynchronously:
  - sync chain = 0, `q_filt` = 0, stability counter = 0;
  - `rise` = `fall` = 0, `trans_cnt` = 0, timestamp = 0;
  - FIFO empty: `evt_valid` = 0, `evt_rise` = 0, `evt_ts` = 0;
  - `overflow` = 0.
- **Sync:** a `SYNC_STAGES` flop chain on `q_in`. `s` denotes the last stage.
- **Filter:** evaluated at each edge.
  - If `s` == `q_filt`, the stability counter clears.
  - Else if the counter == FILT_CYCLES-1: `q_filt` <= `s` and the counter clears.
  - Else the counter increments.
  - Any glitch shorter than FILT_CYCLES synced cycles is discarded.
- **Edges:** `rise`/`fall` are registered. Each is high for exactly the cycle following the edge at which `q_filt` updates, i.e. concurrent with the new `q_filt` value.
- **Timestamp:** free-running TS_W counter, incrementing every cycle and wrapping to 0 after all-ones. An event records the timestamp value present in the cycle before `q_filt` updates.
- **trans_cnt:** +1 per filtered transition; holds at 2^CNT_W-1.
  - `clr_cnt` wins over a simultaneous transition: the result is 0.
- **Event FIFO:** 2 entries, each {rise, ts}. A push occurs on every filtered transition.
  - The head is accepted when `evt_valid` && `evt_ready`.
  - Full with a push and no pop: the new event is dropped and `overflow` <= 1.
  - Full with a push and a pop in the same cycle: the push is accepted and nothing is dropped.
  - Empty with a push: the entry appears at the head the next cycle.
  - Pop without a push: occupancy decrements.
  - `evt_rise`/`evt_ts` must be stable while `evt_valid` && !`evt_ready`.
- **overflow:** sticky; cleared only by `clr_cnt` or reset. If `clr_cnt` coincides with a drop, `overflow` = 1 (the drop wins).

## Timing
- **Latency:** a `q_in` change stable before edge 0 updates `q_filt` at edge SYNC_STAGES+FILT_CYCLES. With defaults this is edge 6; `rise`/`fall` and `evt_valid` are visible after that edge.
- **Minimum accepted pulse:** at least FILT_CYCLES clk periods after synchronisation. Shorter pulses produce no output change.
- **Handshake:** standard valid/ready.
  - `evt_valid` never depends combinationally on `evt_ready`.
  - Throughput is one event per cycle.
- **Reset mid-operation:** all of the above return to reset values immediately. Pending events are lost. The first post-reset event has `ts` counted from 0.
- No combinational path from any input to any output.

## Test plan
- **Reset:** hold `rstn`=0 with `q_in`=1 → all outputs 0. Release `rstn` → `q_filt`=1 at edge 6 after release, `rise`=1 for one cycle, event {rise=1, ts=5}.
- **Glitch:** 3-cycle high pulse on `q_in` (defaults) → no change on `q_filt`, `rise`, `fall` or `trans_cnt`. A 6-cycle pulse → `rise` then `fall`, `trans_cnt`=2, two events with ts difference 6.
- **Saturation:** CNT_W=2, 5 clean toggles → `trans_cnt` sequence 1, 2, 3, 3, 3. `clr_cnt` pulsed on a transition cycle → `trans_cnt`=0.
- **Overflow:** `evt_ready`=0, 3 clean toggles → FIFO holds events 1 and 2, `overflow`=1. Set `evt_ready`=1 → events 1 and 2 pop in order with `ts` intact, then `evt_valid`=0.
- **Full push/pop:** FIFO full, `evt_ready`=1 in the cycle a new transition lands → no drop, `overflow` stays 0, third event delivered.
- **Wrap and reset:** TS_W=4, event after 20 cycles → `ts`=(n mod 16). Async `rstn` pulse mid-filter (counter=2) → filter restarts and `q_filt`=0 until a new full stable window.
